// File: rtl/reg_file_debug_port_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_debug_port_if
// Description : Debug request/response handshake, core halt/idle pair and
//               register file port bundle for reg_file_debug_port.
//               "master" is the debug port's view; "slave" is the view of the
//               surrounding core / debug host.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_debug_port_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) ();
    logic                      i_Dbg_Req_Valid;
    logic                      o_Dbg_Req_Ready;
    logic [1:0]                i_Dbg_Req_Op;
    logic [REG_ADDR_WIDTH-1:0] i_Dbg_Req_Addr;
    logic [XLEN-1:0]           i_Dbg_Req_Data;
    logic                      o_Dbg_Resp_Valid;
    logic                      i_Dbg_Resp_Ready;
    logic [XLEN-1:0]           o_Dbg_Resp_Data;
    logic                      o_Dbg_Resp_Error;
    logic                      o_Cpu_Halt;
    logic                      i_Cpu_Idle;
    logic                      o_Rf_Enable;
    logic [REG_ADDR_WIDTH-1:0] o_Rf_Read_Addr;
    logic [XLEN-1:0]           i_Rf_Read_Data;
    logic [REG_ADDR_WIDTH-1:0] o_Rf_Write_Addr;
    logic [XLEN-1:0]           o_Rf_Write_Data;
    logic                      o_Rf_Write_Enable;

    modport master (
        input  i_Dbg_Req_Valid, i_Dbg_Req_Op, i_Dbg_Req_Addr, i_Dbg_Req_Data,
        input  i_Dbg_Resp_Ready, i_Cpu_Idle, i_Rf_Read_Data,
        output o_Dbg_Req_Ready, o_Dbg_Resp_Valid, o_Dbg_Resp_Data, o_Dbg_Resp_Error,
        output o_Cpu_Halt, o_Rf_Enable, o_Rf_Read_Addr, o_Rf_Write_Addr,
        output o_Rf_Write_Data, o_Rf_Write_Enable
    );

    modport slave (
        output i_Dbg_Req_Valid, i_Dbg_Req_Op, i_Dbg_Req_Addr, i_Dbg_Req_Data,
        output i_Dbg_Resp_Ready, i_Cpu_Idle, i_Rf_Read_Data,
        input  o_Dbg_Req_Ready, o_Dbg_Resp_Valid, o_Dbg_Resp_Data, o_Dbg_Resp_Error,
        input  o_Cpu_Halt, o_Rf_Enable, o_Rf_Read_Addr, o_Rf_Write_Addr,
        input  o_Rf_Write_Data, o_Rf_Write_Enable
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_debug_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_debug_port
// Description : Debug-side initiator for the CPU register file. Accepts read,
//               write and clear-all requests, halts the core, waits for the
//               pipeline to drain, performs the access and returns a single
//               response per request.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_debug_port #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  wire logic             i_Clock,
    input  wire logic             i_Reset_N,
    reg_file_debug_port_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        READ      = 3'd2,
        WRITE     = 3'd3,
        CLEAR     = 3'd4,
        RESP      = 3'd5
    } state_t;

    localparam logic [1:0]                OP_READ   = 2'b00;
    localparam logic [1:0]                OP_WRITE  = 2'b01;
    localparam logic [1:0]                OP_RSVD   = 2'b11;
    localparam logic [REG_ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                    state;
    state_t                    next_state;
    logic [1:0]                req_op;
    logic [REG_ADDR_WIDTH-1:0] req_addr;
    logic [XLEN-1:0]           req_data;
    logic [XLEN-1:0]           rsp_data;
    logic                      rsp_error;
    logic [REG_ADDR_WIDTH-1:0] clear_addr;

    // State register; reset returns to IDLE from any state, abandoning any
    // partially completed clear without a response.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; outputs depend only on state and latched
    // request/response registers, never on live request inputs.
    always_comb begin
        next_state            = state;
        bus.o_Dbg_Req_Ready   = 1'b0;
        bus.o_Dbg_Resp_Valid  = 1'b0;
        bus.o_Dbg_Resp_Data   = '0;
        bus.o_Dbg_Resp_Error  = 1'b0;
        bus.o_Cpu_Halt        = 1'b0;
        bus.o_Rf_Enable       = 1'b0;
        bus.o_Rf_Read_Addr    = '0;
        bus.o_Rf_Write_Addr   = '0;
        bus.o_Rf_Write_Data   = '0;
        bus.o_Rf_Write_Enable = 1'b0;
        case (state)
            IDLE: begin
                bus.o_Dbg_Req_Ready = 1'b1;
                if (bus.i_Dbg_Req_Valid) begin
                    next_state = (bus.i_Dbg_Req_Op == OP_RSVD) ? RESP : HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                bus.o_Cpu_Halt = 1'b1;
                if (bus.i_Cpu_Idle) begin
                    case (req_op)
                        OP_READ:  next_state = READ;
                        OP_WRITE: next_state = WRITE;
                        default:  next_state = CLEAR;
                    endcase
                end
            end
            READ: begin
                bus.o_Cpu_Halt     = 1'b1;
                bus.o_Rf_Enable    = 1'b1;
                bus.o_Rf_Read_Addr = req_addr;
                next_state         = RESP;
            end
            WRITE: begin
                bus.o_Cpu_Halt        = 1'b1;
                bus.o_Rf_Enable       = 1'b1;
                bus.o_Rf_Write_Addr   = req_addr;
                bus.o_Rf_Write_Data   = req_data;
                // x0 is hardwired to zero, so a write there is dropped
                bus.o_Rf_Write_Enable = (req_addr != '0);
                next_state            = RESP;
            end
            CLEAR: begin
                bus.o_Cpu_Halt        = 1'b1;
                bus.o_Rf_Enable       = 1'b1;
                bus.o_Rf_Write_Addr   = clear_addr;
                bus.o_Rf_Write_Enable = 1'b1;
                if (clear_addr == LAST_ADDR) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                bus.o_Dbg_Resp_Valid = 1'b1;
                bus.o_Dbg_Resp_Data  = rsp_data;
                bus.o_Dbg_Resp_Error = rsp_error;
                if (bus.i_Dbg_Resp_Ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch, response register and clear-all address counter.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            req_op     <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
            clear_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_Dbg_Req_Valid) begin
                        req_op     <= bus.i_Dbg_Req_Op;
                        req_addr   <= bus.i_Dbg_Req_Addr;
                        req_data   <= bus.i_Dbg_Req_Data;
                        rsp_data   <= '0;
                        rsp_error  <= (bus.i_Dbg_Req_Op == OP_RSVD);
                        // clear-all starts at x1 so x0 is never written
                        clear_addr <= REG_ADDR_WIDTH'(1);
                    end
                end
                READ: begin
                    rsp_data <= bus.i_Rf_Read_Data;
                end
                CLEAR: begin
                    // Hold at the last address instead of wrapping to x0;
                    // starting at 1, the final address equals the write count.
                    if (clear_addr != LAST_ADDR) begin
                        clear_addr <= clear_addr + REG_ADDR_WIDTH'(1);
                    end else begin
                        rsp_data <= XLEN'(clear_addr);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_debug_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_debug_port
// Description : Self-checking bench for reg_file_debug_port: directed vector
//               table, randomized traffic against a register-array reference
//               model, and a reset-during-clear sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_debug_port;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    logic clk;
    logic rst_n;

    reg_file_debug_port_if #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW)) bus ();

    reg_file_debug_port #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW)) dut (
        .i_Clock   (clk),
        .i_Reset_N (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment register file: x0 reads as zero, combinational read port.
    logic [XLEN-1:0] rf_env [NREG];
    // Reference model of architectural register contents.
    logic [XLEN-1:0] mdl [NREG];
    // Write pulses observed during the current transaction.
    logic [AW-1:0]   wq_addr [$];
    logic [XLEN-1:0] wq_data [$];

    int checks = 0;
    int passes = 0;

    assign bus.i_Rf_Read_Data = rf_env[bus.o_Rf_Read_Addr];

    // Environment register file update and write-pulse capture.
    always @(posedge clk) begin
        if (bus.o_Rf_Write_Enable) begin
            wq_addr.push_back(bus.o_Rf_Write_Addr);
            wq_data.push_back(bus.o_Rf_Write_Data);
            if (bus.o_Rf_Write_Addr != '0) rf_env[bus.o_Rf_Write_Addr] = bus.o_Rf_Write_Data;
        end
    end

    task automatic check(input logic ok, input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Issue one request, raise i_Cpu_Idle after idle_delay halted cycles,
    // hold off the response for hold cycles, and check it against the model.
    task automatic transact(input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [XLEN-1:0] data, input int idle_delay, input int hold,
                            output logic [XLEN-1:0] rdata, output logic rerr);
        int lat, halt_cycles, exp_lat;
        logic clean, stable, ok;
        logic [XLEN-1:0] d0, exp_data;
        logic e0, exp_err;
        logic [AW-1:0]   ea [$];
        logic [XLEN-1:0] ed [$];

        // model: expected response, write pulses and latency
        exp_err  = (op == 2'b11);
        exp_data = '0;
        exp_lat  = idle_delay + 2;
        case (op)
            2'b00: exp_data = mdl[addr];
            2'b01: if (addr != 0) begin
                       ea.push_back(addr); ed.push_back(data); mdl[addr] = data;
                   end
            2'b10: begin
                       for (int i = 1; i < NREG; i++) begin
                           ea.push_back(AW'(i)); ed.push_back('0); mdl[i] = '0;
                       end
                       exp_data = NREG - 1;
                       exp_lat  = idle_delay + 1 + (NREG - 1);
                   end
            default: exp_lat = 0;
        endcase

        @(negedge clk);
        wq_addr.delete(); wq_data.delete();
        bus.i_Dbg_Req_Valid = 1'b1;
        bus.i_Dbg_Req_Op    = op;
        bus.i_Dbg_Req_Addr  = addr;
        bus.i_Dbg_Req_Data  = data;
        bus.i_Cpu_Idle      = (idle_delay == 0);
        @(negedge clk);
        // scramble request inputs after acceptance; they must be ignored
        bus.i_Dbg_Req_Valid = 1'($urandom);
        bus.i_Dbg_Req_Op    = 2'($urandom);
        bus.i_Dbg_Req_Addr  = AW'($urandom);
        bus.i_Dbg_Req_Data  = $urandom;
        lat = 0; halt_cycles = 0; clean = 1'b1;
        while (!bus.o_Dbg_Resp_Valid && lat < 200) begin
            if (bus.o_Cpu_Halt) halt_cycles++;
            if (lat < idle_delay && (!bus.o_Cpu_Halt || bus.o_Rf_Enable || bus.o_Rf_Write_Enable))
                clean = 1'b0;
            bus.i_Cpu_Idle = (lat >= idle_delay);
            @(negedge clk);
            lat++;
        end
        bus.i_Dbg_Req_Valid = 1'b0;
        check(bus.o_Dbg_Resp_Valid, "resp_timeout", 32'(lat), 32'(exp_lat));
        check(lat == exp_lat, "latency", 32'(lat), 32'(exp_lat));
        check(bus.o_Dbg_Resp_Data == exp_data, "resp_data", bus.o_Dbg_Resp_Data, exp_data);
        check(bus.o_Dbg_Resp_Error == exp_err, "resp_error", 32'(bus.o_Dbg_Resp_Error), 32'(exp_err));
        check((halt_cycles > 0) == !exp_err, "halt_seen", 32'(halt_cycles), 32'(!exp_err));
        if (idle_delay > 0) check(clean, "stall_quiet", 32'(clean), 32'd1);
        ok = (wq_addr.size() == ea.size());
        if (ok) foreach (ea[i]) if (wq_addr[i] != ea[i] || wq_data[i] != ed[i]) ok = 1'b0;
        check(ok, "write_pulses", 32'(wq_addr.size()), 32'(ea.size()));

        d0 = bus.o_Dbg_Resp_Data; e0 = bus.o_Dbg_Resp_Error; stable = 1'b1;
        bus.i_Dbg_Resp_Ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.o_Dbg_Resp_Valid || bus.o_Dbg_Resp_Data != d0 || bus.o_Dbg_Resp_Error != e0 ||
                bus.o_Dbg_Req_Ready || bus.o_Cpu_Halt) stable = 1'b0;
        end
        if (hold > 0) check(stable, "resp_stable", 32'(stable), 32'd1);
        bus.i_Dbg_Resp_Ready = 1'b1;
        @(negedge clk);
        bus.i_Dbg_Resp_Ready = 1'b0;
        check(bus.o_Dbg_Req_Ready && !bus.o_Dbg_Resp_Valid, "back_to_idle",
              32'({bus.o_Dbg_Req_Ready, bus.o_Dbg_Resp_Valid}), 32'b10);
        rdata = d0; rerr = e0;
    endtask

    typedef struct {
        logic [1:0]      op;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        int              idle_delay;
        int              hold;
        logic [XLEN-1:0] exp_data;
        logic            exp_err;
    } vec_t;

    vec_t vecs [8];
    logic [XLEN-1:0] rd, pre11;
    logic            re;

    initial begin
        vecs[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 0,  0, 32'h0,        1'b0};
        vecs[1] = '{2'b00, 5'd5,  32'h0,        0,  0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{2'b01, 5'd0,  32'h12345678, 0,  1, 32'h0,        1'b0};
        vecs[3] = '{2'b00, 5'd0,  32'h0,        0,  0, 32'h0,        1'b0};
        vecs[4] = '{2'b00, 5'd5,  32'h0,        10, 0, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{2'b11, 5'd7,  32'h55555555, 0,  5, 32'h0,        1'b1};
        vecs[6] = '{2'b01, 5'd31, 32'hA5A5A5A5, 3,  2, 32'h0,        1'b0};
        vecs[7] = '{2'b00, 5'd31, 32'h0,        0,  0, 32'hA5A5A5A5, 1'b0};

        for (int i = 0; i < NREG; i++) begin rf_env[i] = '0; mdl[i] = '0; end
        bus.i_Dbg_Req_Valid = 1'b0; bus.i_Dbg_Req_Op = '0; bus.i_Dbg_Req_Addr = '0;
        bus.i_Dbg_Req_Data = '0; bus.i_Dbg_Resp_Ready = 1'b0; bus.i_Cpu_Idle = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check(bus.o_Dbg_Req_Ready && !bus.o_Dbg_Resp_Valid && !bus.o_Cpu_Halt && !bus.o_Rf_Enable &&
              !bus.o_Rf_Write_Enable && bus.o_Dbg_Resp_Data == '0 && !bus.o_Dbg_Resp_Error &&
              bus.o_Rf_Read_Addr == '0 && bus.o_Rf_Write_Addr == '0 && bus.o_Rf_Write_Data == '0,
              "reset_state", 32'({bus.o_Dbg_Req_Ready, bus.o_Cpu_Halt, bus.o_Rf_Write_Enable}), 32'b100);
        rst_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 8; i++) begin
            transact(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].idle_delay, vecs[i].hold, rd, re);
            check(rd == vecs[i].exp_data && re == vecs[i].exp_err, $sformatf("vec%0d", i),
                  rd, vecs[i].exp_data);
        end

        // preload, clear-all, then every register must read back zero
        for (int i = 1; i < NREG; i++) transact(2'b01, AW'(i), $urandom | 32'h1, 0, 0, rd, re);
        transact(2'b10, 5'd0, 32'h0, 1, 0, rd, re);
        check(rd == 32'd31, "clear_count", rd, 32'd31);
        for (int i = 0; i < NREG; i++) begin
            transact(2'b00, AW'(i), 32'h0, 0, 0, rd, re);
            check(rd == '0, "read_after_clear", rd, 32'h0);
        end

        // randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            int r;
            logic [1:0] op;
            r  = $urandom_range(0, 99);
            op = (r < 45) ? 2'b00 : (r < 85) ? 2'b01 : (r < 93) ? 2'b10 : 2'b11;
            transact(op, AW'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3), rd, re);
        end

        // reset in the middle of a clear-all at counter = 10
        for (int i = 1; i < NREG; i++) transact(2'b01, AW'(i), 32'hC0DE0000 | i, 0, 0, rd, re);
        pre11 = rf_env[11];
        @(negedge clk);
        bus.i_Dbg_Req_Valid = 1'b1; bus.i_Dbg_Req_Op = 2'b10; bus.i_Cpu_Idle = 1'b1;
        @(negedge clk);
        bus.i_Dbg_Req_Valid = 1'b0;
        begin
            int guard = 0;
            while (!(bus.o_Rf_Write_Enable && bus.o_Rf_Write_Addr == 5'd10) && guard < 100) begin
                @(negedge clk); guard++;
            end
            check(guard < 100, "clear_reach_10", 32'(guard), 32'd0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check(!bus.o_Cpu_Halt && !bus.o_Rf_Write_Enable && !bus.o_Dbg_Resp_Valid && bus.o_Dbg_Req_Ready,
              "reset_mid_clear", 32'({bus.o_Cpu_Halt, bus.o_Rf_Write_Enable, bus.o_Dbg_Resp_Valid}), 32'h0);
        rst_n = 1'b1;
        begin
            logic quiet = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (bus.o_Dbg_Resp_Valid || bus.o_Cpu_Halt || bus.o_Rf_Write_Enable) quiet = 1'b0;
            end
            check(quiet, "no_resp_after_reset", 32'(quiet), 32'd1);
        end
        begin
            logic z = 1'b1;
            for (int i = 1; i < 10; i++) if (rf_env[i] != '0) z = 1'b0;
            check(z, "cleared_1_to_9", 32'(z), 32'd1);
        end
        check(rf_env[11] == pre11, "reg11_kept", rf_env[11], pre11);
        for (int i = 1; i < 10; i++) mdl[i] = '0;
        mdl[10] = rf_env[10];
        transact(2'b00, 5'd9, 32'h0, 0, 0, rd, re);
        transact(2'b00, 5'd11, 32'h0, 0, 0, rd, re);
        check(rd == (32'hC0DE0000 | 32'd11), "read_reg11", rd, 32'hC0DE0000 | 32'd11);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_debug_port.md
Name: reg_file_debug_port

Overview:
- Debug-side initiator for the CPU register file. Accepts read, write and clear-all requests over a valid/ready handshake and drives the register file's read and write ports.
- Returns one response per request.
- Halts the core and waits for the pipeline to drain before touching the register file.
- While o_Cpu_Halt is high, the core-level port mux hands the register file ports to this block.

Parameters:
XLEN, 32, data width of a register.
REG_ADDR_WIDTH, 5, register address width; register count is 1<<REG_ADDR_WIDTH.

Ports:
i_Clock  in  1  core clock
i_Reset_N  in  1  synchronous active-low reset
i_Dbg_Req_Valid  in  1  request valid
o_Dbg_Req_Ready  out  1  request accepted when valid&&ready
i_Dbg_Req_Op  in  2  00 read, 01 write, 10 clear-all, 11 reserved
i_Dbg_Req_Addr  in  REG_ADDR_WIDTH  target register
i_Dbg_Req_Data  in  XLEN  write data
o_Dbg_Resp_Valid  out  1  response valid
i_Dbg_Resp_Ready  in  1  response consumed when valid&&ready
o_Dbg_Resp_Data  out  XLEN  read data / clear count / 0
o_Dbg_Resp_Error  out  1  reserved op
o_Cpu_Halt  out  1  core must stall and release register file ports
i_Cpu_Idle  in  1  core pipeline drained
o_Rf_Enable  out  1  register file enable
o_Rf_Read_Addr  out  REG_ADDR_WIDTH  register file read address 1
i_Rf_Read_Data  in  XLEN  register file read data 1 (combinational)
o_Rf_Write_Addr  out  REG_ADDR_WIDTH  write address
o_Rf_Write_Data  out  XLEN  write data
o_Rf_Write_Enable  out  1  write strobe

Behaviour:
- Clock and reset: single clock. Synchronous active-low reset i_Reset_N is sampled on the rising edge of i_Clock.
- Reset values:
  - State IDLE.
  - All outputs 0, except o_Dbg_Req_Ready, which is 1.
  - Internal request latch and clear counter cleared.
- States: IDLE, HALT_WAIT, READ, WRITE, CLEAR, RESP. All outputs are registered or decoded from state only.
- IDLE:
  - o_Dbg_Req_Ready=1.
  - On valid&&ready, latch op/addr/data.
  - Op 11 → RESP with Error=1, Data=0; no halt.
  - Any other op → HALT_WAIT.
- HALT_WAIT:
  - o_Cpu_Halt=1.
  - Stays until i_Cpu_Idle=1, then → READ, WRITE or CLEAR according to op.
  - Waits indefinitely.
- READ (1 cycle):
  - o_Rf_Enable=1, o_Rf_Read_Addr=addr.
  - i_Rf_Read_Data captured into the response register at the end of the cycle → RESP.
  - Addr 0 returns whatever the register file returns, which is 0.
- WRITE (1 cycle):
  - o_Rf_Enable=1, Write_Addr=addr, Write_Data=data.
  - o_Rf_Write_Enable=1 only if addr!=0; addr 0 is silently skipped.
  - Response Data=0, Error=0 → RESP.
- CLEAR:
  - 5-bit counter (REG_ADDR_WIDTH) starts at 1.
  - Each cycle: Write_Enable=1, Write_Addr=counter, Write_Data=0.
  - After writing address (1<<REG_ADDR_WIDTH)-1 → RESP.
  - The counter must not wrap to 0; no write to x0 ever.
  - Response Data = number of registers written (31 at default).
- RESP:
  - o_Dbg_Resp_Valid=1; Data and Error held stable until i_Dbg_Resp_Ready.
  - On handshake → IDLE the next cycle. Back-to-back accept is not allowed in the handshake cycle.
- o_Cpu_Halt: 1 in HALT_WAIT/READ/WRITE/CLEAR; 0 in IDLE/RESP.
- o_Rf_*: zero whenever not in READ/WRITE/CLEAR.
- Latency: read accepted at edge T with i_Cpu_Idle=1 → HALT_WAIT T+1, READ T+2, Resp_Valid from T+3. Write is the same. Clear-all: Resp_Valid at T+2+31.
- Input changes: changes on the i_Dbg_Req_* inputs after acceptance are ignored.
- Reset mid-operation: any state → IDLE on the next edge. Halt and write enable drop immediately at that edge. Any partially completed clear is left as-is; no response is issued.

Test Plan:
- Reset, then write op 01 addr 5 data 0xDEADBEEF with i_Cpu_Idle=1 → exactly one Write_Enable pulse at addr 5, response Data=0, Error=0. Read addr 5 → Resp_Data=0xDEADBEEF at T+3.
- Write addr 0 data 0x12345678 → no Write_Enable pulse. Read addr 0 → Resp_Data=0.
- Hold i_Cpu_Idle=0 for 10 cycles after a read request → o_Cpu_Halt high and no Rf activity for those cycles. Read completes 2 cycles after Idle rises.
- Preload x1..x31 with nonzero values, then op 10 → 31 consecutive write pulses at addresses 1..31 with data 0, never addr 0. Resp_Data=31. Subsequent reads all return 0.
- Op 11 → Resp_Error=1 and Data=0 at T+1; o_Cpu_Halt never asserted. Hold i_Dbg_Resp_Ready=0 for 5 cycles → response stable and o_Dbg_Req_Ready=0 throughout.
- Assert i_Reset_N=0 during the CLEAR cycle at counter=10 → next edge: IDLE, Halt=0, Write_Enable=0, no response. Registers 1..9 (and 10 if written before the edge) are zero; register 11 is unchanged.
